// File: rtl/ldpcenc_pkg.sv
// Shared definitions for the LDPC encoder output path.
// Mode fields, length codes, lifting sizes and FSM encoding.
package ldpcenc_pkg;

  localparam int MODE_RATE_LO = 0;
  localparam int MODE_RATE_HI = 1;
  localparam int MODE_LEN_LO  = 2;
  localparam int MODE_LEN_HI  = 3;

  localparam logic [1:0] LEN_648  = 2'd0;
  localparam logic [1:0] LEN_1296 = 2'd1;
  localparam logic [1:0] LEN_1944 = 2'd2;
  localparam logic [1:0] LEN_ILL  = 2'd3;

  localparam int Z_648  = 27;
  localparam int Z_1296 = 54;
  localparam int Z_1944 = 81;

  localparam int WORD_W = 27;
  localparam int BYTE_W = 8;
  localparam int ACC_W  = 34;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  function automatic logic [1:0] len_norm(
    input logic [1:0] l
  );
    return (l == LEN_ILL) ? LEN_1944 : l;
  endfunction

  function automatic logic [6:0] z_of(
    input logic [1:0] l
  );
    unique case (l)
      LEN_648:  return 7'(Z_648);
      LEN_1296: return 7'(Z_1296);
      default:  return 7'(Z_1944);
    endcase
  endfunction

  function automatic logic [6:0] words_per_cw(
    input logic [1:0] l
  );
    return 7'd24 * ({5'd0, l} + 7'd1);
  endfunction

  // 8 words of 27 bits make 27 bytes, so B = 3*Z
  function automatic logic [7:0] bytes_per_cw(
    input logic [1:0] l
  );
    return 8'd3 * {1'b0, z_of(l)};
  endfunction

endpackage

// File: rtl/ldpcenc_obuf_mem.sv
// Codeword word store: one write port, one registered read port.
// No reset on the array; read data is qualified by the caller.
module ldpcenc_obuf_mem #(
  parameter int DEPTH = 72,
  parameter int W     = 27,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ldpcenc_obuf.sv
// Captures one LDPC codeword of 27-bit words and drains it
// as a framed byte stream with valid/ready handshake.
module ldpcenc_obuf
  import ldpcenc_pkg::*;
#(
  parameter int NWORD_MAX = 72
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        srst,
  input  logic        vld_in,
  input  logic        sop_in,
  input  logic [3:0]  mode_in,
  input  logic [26:0] data_in,
  output logic        cw_rdy,
  output logic        out_vld,
  input  logic        out_rdy,
  output logic [7:0]  out_data,
  output logic        out_sop,
  output logic        out_eop,
  output logic        err_drop,
  output logic [1:0]  state
);

  localparam int AW = $clog2(NWORD_MAX);

  state_e              r_state, w_nstate;
  logic [1:0]          r_len;
  logic [AW-1:0]       r_waddr, r_raddr;
  logic                r_cw_rdy, r_err;
  logic                r_rd_vld;
  logic [5:0]          r_cnt;
  logic [ACC_W-1:0]    r_acc;
  logic [7:0]          r_bcnt;
  logic                r_vld, r_sop, r_eop;
  logic [7:0]          r_data;

  logic                w_we, w_drop, w_re, w_pop, w_xfer;
  logic [AW-1:0]       w_mem_waddr, w_words, w_wlast;
  logic [WORD_W-1:0]   w_rdata;
  logic [ACC_W-1:0]    w_cat;
  logic [5:0]          w_avail, w_left;
  logic [7:0]          w_blast;
  logic                w_unused_rate;

  assign w_unused_rate = ^mode_in[MODE_RATE_HI:MODE_RATE_LO];
  assign w_words = AW'(words_per_cw(r_len));
  assign w_wlast = w_words - AW'(1);
  assign w_blast = bytes_per_cw(r_len) - 8'd1;
  assign w_mem_waddr = sop_in ? '0 : r_waddr;

  always_comb begin
    w_nstate = r_state;
    w_we     = 1'b0;
    w_drop   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (vld_in && sop_in) begin
          w_we     = 1'b1;
          w_nstate = S_FILL;
        end
      end
      S_FILL: begin
        if (vld_in) begin
          w_we = 1'b1;
          if (sop_in) w_drop = 1'b1;
          else if (r_waddr == w_wlast) w_nstate = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_drop = vld_in;
        if (w_xfer && r_eop) w_nstate = S_IDLE;
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cw_rdy <= 1'b1;
      r_err    <= 1'b0;
      r_len    <= '0;
      r_waddr  <= '0;
    end else if (srst) begin
      r_state  <= S_IDLE;
      r_cw_rdy <= 1'b1;
      r_err    <= 1'b0;
      r_len    <= '0;
      r_waddr  <= '0;
    end else begin
      r_state  <= w_nstate;
      r_cw_rdy <= (w_nstate == S_IDLE);
      r_err    <= w_drop;
      if (w_we && sop_in) begin
        r_len   <= len_norm(mode_in[MODE_LEN_HI:MODE_LEN_LO]);
        r_waddr <= AW'(1);
      end else if (w_we) begin
        r_waddr <= r_waddr + AW'(1);
      end
    end
  end

  // Gearbox: left-aligned accumulator, next word lands right after r_cnt bits
  assign w_xfer  = r_vld && out_rdy;
  assign w_avail = r_cnt + (r_rd_vld ? 6'd27 : 6'd0);
  assign w_cat   = r_acc | (r_rd_vld ?
                   ({w_rdata, {(ACC_W-WORD_W){1'b0}}} >> r_cnt) : '0);
  assign w_pop   = (r_state == S_DRAIN) && (!r_vld || out_rdy)
                   && (w_avail >= 6'd8);
  assign w_left  = w_avail - (w_pop ? 6'd8 : 6'd0);
  // Prefetch only when the next cycle would otherwise starve
  assign w_re    = (r_state == S_DRAIN) && (r_raddr < w_words)
                   && (w_left < 6'd8);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_vld <= 1'b0;
      r_raddr  <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_bcnt   <= '0;
      r_vld    <= 1'b0;
      r_sop    <= 1'b0;
      r_eop    <= 1'b0;
      r_data   <= '0;
    end else if (srst) begin
      r_rd_vld <= 1'b0;
      r_raddr  <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_bcnt   <= '0;
      r_vld    <= 1'b0;
      r_sop    <= 1'b0;
      r_eop    <= 1'b0;
      r_data   <= '0;
    end else begin
      r_rd_vld <= w_re;
      r_acc    <= w_pop ? (w_cat << BYTE_W) : w_cat;
      r_cnt    <= w_left;
      if (r_state != S_DRAIN) begin
        r_raddr <= '0;
        r_bcnt  <= '0;
      end else begin
        if (w_re)  r_raddr <= r_raddr + AW'(1);
        if (w_pop) r_bcnt  <= r_bcnt + 8'd1;
      end
      if (w_pop) begin
        r_vld  <= 1'b1;
        r_data <= w_cat[ACC_W-1 -: BYTE_W];
        r_sop  <= (r_bcnt == 8'd0);
        r_eop  <= (r_bcnt == w_blast);
      end else if (w_xfer) begin
        r_vld <= 1'b0;
        r_sop <= 1'b0;
        r_eop <= 1'b0;
      end
    end
  end

  ldpcenc_obuf_mem #(
    .DEPTH (NWORD_MAX),
    .W     (WORD_W),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_mem_waddr),
    .i_wdata (data_in),
    .i_re    (w_re),
    .i_raddr (r_raddr),
    .o_rdata (w_rdata)
  );

  assign cw_rdy   = r_cw_rdy;
  assign out_vld  = r_vld;
  assign out_data = r_data;
  assign out_sop  = r_sop;
  assign out_eop  = r_eop;
  assign err_drop = r_err;
  assign state    = r_state;

endmodule
